piccolo_stream_io: RTL and testbench

Byte-stream front/back end for the Piccolo encryption core. It collects 8 plaintext bytes over a valid/ready handshake and presents the 64-bit block to the core. It then drives the core's active-high load/reset, counts the core's iteration cycles, and captures the ciphertext. The ciphertext is returned as 8 bytes over a second valid/ready handshake. Instantiated directly around `piccolo`: its `core_*` ports connect to the core's `reset`, `version`, `plaintext` and `ciphertext`.

---
 rtl/piccolo_stream_io.sv | 105 ++++++++++
 tb/tb_piccolo_stream_io.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/piccolo_stream_io.sv
// Byte-stream wrapper around the Piccolo core: gathers 8 plaintext bytes, runs the
// core for a fixed number of update cycles, then streams the 8 ciphertext bytes out.
`timescale 1ns/1ps
module piccolo_stream_io #(
  parameter int LAT80  = 4,
  parameter int LAT128 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_version,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        core_reset,
  output logic        core_version,
  output logic [63:0] core_plaintext,
  input  logic [63:0] core_ciphertext,
  output logic [15:0] blocks_done
);

  typedef enum logic [1:0] {LOAD, KICK, RUN, UNLOAD} state_t;

  // Observable FSM state for checkers.
  state_t      state;
  logic [2:0]  bcnt;
  logic [7:0]  ccnt;
  logic [2:0]  ocnt;
  logic [63:0] sreg;
  logic [7:0]  lat;

  assign lat        = core_version ? 8'(LAT128) : 8'(LAT80);
  assign in_ready   = (state == LOAD);
  assign busy       = (state != LOAD);
  assign core_reset = (state == LOAD) || (state == KICK);

  // Handshakes: a byte transfers on a rising edge where valid and ready are both
  // high; valid/data/last are held unchanged until that edge, and ready/valid
  // never depend combinationally on the other side's signal.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= LOAD;
      bcnt           <= 3'd0;
      ccnt           <= 8'd0;
      ocnt           <= 3'd0;
      sreg           <= 64'd0;
      core_plaintext <= 64'd0;
      core_version   <= 1'b0;
      blocks_done    <= 16'd0;
      out_valid      <= 1'b0;
      out_data       <= 8'h00;
      out_last       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            // First byte lands in the most significant slot (plaintext[0:7]).
            core_plaintext[{~bcnt, 3'b000} +: 8] <= in_data;
            if (bcnt == 3'd0) core_version <= in_version;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= KICK;
          end
        end
        KICK: begin
          ccnt  <= 8'd0;
          state <= RUN;
        end
        RUN: begin
          if (ccnt == lat) begin
            sreg        <= core_ciphertext;
            out_data    <= core_ciphertext[63:56];
            out_valid   <= 1'b1;
            out_last    <= 1'b0;
            ocnt        <= 3'd0;
            blocks_done <= blocks_done + 16'd1;
            state       <= UNLOAD;
          end else begin
            ccnt <= ccnt + 8'd1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (ocnt == 3'd7) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              ocnt      <= 3'd0;
              state     <= LOAD;
            end else begin
              sreg     <= {sreg[55:0], 8'h00};
              out_data <= sreg[55:48];
              out_last <= (ocnt == 3'd6);
              ocnt     <= ocnt + 3'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo_stream_io.sv
// Bench for piccolo_stream_io using a deterministic stub core whose state evolves
// once per non-reset edge, so the captured value pins down the exact latency.
`timescale 1ns/1ps
module tb_piccolo_stream_io;

  localparam logic [63:0] KEY = 64'h5A3C_96F0_0F69_C3A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_version;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic        core_reset;
  logic        core_version;
  logic [63:0] core_plaintext;
  logic [63:0] core_ciphertext;
  logic [15:0] blocks_done;

  logic [63:0] stub;
  logic [8:0]  exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_done;
  logic        stalled = 1'b0;
  logic [7:0]  held_d;
  logic        held_l;

  piccolo_stream_io #(.LAT80(4), .LAT128(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_version(in_version), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .core_reset(core_reset), .core_version(core_version),
    .core_plaintext(core_plaintext), .core_ciphertext(core_ciphertext),
    .blocks_done(blocks_done)
  );

  // Clock and stub core
  always #5 clk = ~clk;

  function automatic logic [63:0] upd(input logic [63:0] v);
    return {v[55:0], v[63:56]} + 64'h1;
  endfunction

  always @(posedge clk) stub <= core_reset ? (core_plaintext ^ KEY) : upd(stub);
  assign core_ciphertext = stub;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks hold under stall
  always @(negedge clk) begin
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_last", out_last, held_l);
      end
      if (out_valid && out_ready) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_byte", {out_last, out_data}, exp_q.pop_front());
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_plaintext"}, core_plaintext, 0);
    check({tag, "_version"}, core_version, 0);
    check({tag, "_blocks_done"}, blocks_done, 0);
  endtask

  task automatic send_bytes(input logic [63:0] pt, input logic v1, input logic vr);
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_data    = pt[8*(7-i) +: 8];
      in_version = (i == 0) ? v1 : vr;
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_expected(input logic [63:0] pt, input logic v1);
    logic [63:0] ct;
    ct = pt ^ KEY;
    for (int i = 0; i < (v1 ? 5 : 4); i++) ct = upd(ct);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), ct[8*(7-i) +: 8]});
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_block(input logic [63:0] pt, input logic v1, input logic vr,
                           input bit rnd, input bit poke);
    int n;
    send_bytes(pt, v1, vr);
    push_expected(pt, v1);
    check("kick_plaintext", core_plaintext, pt);
    check("kick_version", core_version, v1);
    check("kick_busy", busy, 1);
    check("kick_core_reset", core_reset, 1);
    if (poke) begin
      in_valid   = 1'b1;
      in_data    = 8'hA5;
      in_version = ~v1;
    end
    wait_out_valid(n);
    check("latency", n, v1 ? 7 : 6);
    check("unload_core_reset", core_reset, 0);
    check("unload_in_ready", in_ready, 0);
    n = 0;
    while (!in_ready && n < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("drain_done", in_ready, 1);
    check("pt_held", core_plaintext, pt);
    check("ver_held", core_version, v1);
    check("queue_empty", exp_q.size(), 0);
    exp_done = exp_done + 16'd1;
    check("blocks_done", blocks_done, exp_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_version = 1'b0; out_ready = 1'b1;
    exp_done = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed 80-bit and 128-bit blocks (version changes after byte 1 ignored)
    run_block(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_block({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random backpressure with input pokes while busy
    for (int k = 0; k < 4; k++)
      run_block({$urandom, $urandom}, 1'(k), 1'(k + 1), 1'b1, 1'b1);

    // Reset during RUN with ccnt=2
    send_bytes(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_busy", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("rst_run");
    reset = 1'b1;
    exp_done = 16'd0;
    run_block(64'h1122_3344_5566_7788, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during UNLOAD with ocnt=3
    send_bytes(64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
    push_expected(64'hCAFE_F00D_1234_5678, 1'b0);
    wait_out_valid(n);
    check("mid_unload_latency", n, 6);
    repeat (3) @(posedge clk);
    #1;
    check("mid_unload_pops", exp_q.size(), 5);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_vals("rst_unload");
    reset = 1'b1;
    exp_done = 16'd0;
    run_block({$urandom, $urandom}, 1'b1, 1'b0, 1'b1, 1'b0);

    // blocks_done wrap
    force dut.blocks_done = 16'hFFFF;
    @(posedge clk); #1;
    release dut.blocks_done;
    check("preload", blocks_done, 16'hFFFF);
    exp_done = 16'hFFFF;
    run_block({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
